// File: rtl/exu_pkg.sv
// exu_pkg: shared widths, ALU op encodings, instruction-type codes, FSM state
// encodings and the packed decode->execute bundle layout for the execute unit.
package exu_pkg;

  localparam int unsigned DATA_WIDTH       = 32;
  localparam int unsigned RD_LEN_STA       = 5;
  localparam int unsigned SHAMT_WIDTH      = 5;
  localparam int unsigned ALUOP_WIDTH      = 4;
  localparam int unsigned FU_ID_WIDTH      = 2;
  localparam int unsigned INSTR_TYPE_WIDTH = 3;
  localparam int unsigned EXU_ST_WIDTH     = 2;

  // alu_op = {bit30, func3}; 'x' positions of the ISA table are encoded as 0 here
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD  = 4'b0000;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB  = 4'b1000;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLL  = 4'b0001;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLT  = 4'b0010;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLTU = 4'b0011;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_XOR  = 4'b0100;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRL  = 4'b0101;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRA  = 4'b1101;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR   = 4'b0110;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND  = 4'b0111;

  localparam logic [EXU_ST_WIDTH-1:0] EXU_ST_IDLE = 2'd0;
  localparam logic [EXU_ST_WIDTH-1:0] EXU_ST_EXEC = 2'd1;
  localparam logic [EXU_ST_WIDTH-1:0] EXU_ST_WB   = 2'd2;
  localparam logic [EXU_ST_WIDTH-1:0] EXU_ST_HALT = 2'd3;

  typedef enum logic [EXU_ST_WIDTH-1:0] {
    EXU_IDLE = EXU_ST_IDLE,
    EXU_EXEC = EXU_ST_EXEC,
    EXU_WB   = EXU_ST_WB,
    EXU_HALT = EXU_ST_HALT
  } exu_st_e;

  typedef enum logic [INSTR_TYPE_WIDTH-1:0] {
    IT_R      = 3'd0,
    IT_I      = 3'd1,
    IT_ISHIFT = 3'd2,
    IT_LOAD   = 3'd3,
    IT_STORE  = 3'd4,
    IT_BRANCH = 3'd5,
    IT_ECALL  = 3'd6,
    IT_EBREAK = 3'd7
  } instr_type_e;

  typedef struct packed {
    logic [RD_LEN_STA-1:0]  rs1;
    logic [RD_LEN_STA-1:0]  rs2;
    logic [RD_LEN_STA-1:0]  rd;
    logic [DATA_WIDTH-1:0]  rs1_val;
    logic [DATA_WIDTH-1:0]  rs2_val;
    logic [DATA_WIDTH-1:0]  imm;
    logic [DATA_WIDTH-1:0]  pc;
    logic [FU_ID_WIDTH-1:0] fu_id;
    instr_type_e            instr_type;
    logic                   use_rs1;
    logic                   use_rs2;
    logic                   use_imm;
    logic                   use_rd;
    logic                   invld_instr;
    logic [ALUOP_WIDTH-1:0] alu_op;
  } dyn_instr_t;

  localparam int unsigned DYN_INST_WIDTH = $bits(dyn_instr_t);

endpackage

// File: rtl/exu_shifter.sv
// exu_shifter: iterative one-bit-per-cycle shifter.
//   load      : capture operand, shift amount and direction/arith controls
//   step      : advance one bit position while the counter is non-zero
//   result_c  : value after the current step (operand itself when counter is 0)
//   done_c    : current step is the last one (counter <= 1)
module exu_shifter
  import exu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   step,
  input  logic                   left,
  input  logic                   arith,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  result_c,
  output logic                   done_c
);

  logic [DATA_WIDTH-1:0]  value;
  logic [DATA_WIDTH-1:0]  shifted_c;
  logic [SHAMT_WIDTH-1:0] count;
  logic                   left_q;
  logic                   arith_q;

  // One-position shift of the held value
  always_comb begin
    shifted_c = value >> 1;
    if (left_q) begin
      shifted_c = value << 1;
    end else if (arith_q) begin
      shifted_c = {value[DATA_WIDTH-1], value[DATA_WIDTH-1:1]};
    end
  end

  assign result_c = (count != '0) ? shifted_c : value;
  assign done_c   = (count <= SHAMT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value   <= '0;
      count   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      value   <= a;
      count   <= shamt;
      left_q  <= left;
      arith_q <= arith;
    end else if (step && (count != '0)) begin
      value <= shifted_c;
      count <= count - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/exu.sv
// exu: execute/writeback unit. Accepts one decode bundle at a time, runs the
// ALU op (shifts iterate one bit per cycle) and emits a one-cycle writeback.
//   clk, rst_n          : clock, async active-low reset
//   dyn_instr_idu_i     : packed decode bundle (dyn_instr_t)
//   dyn_valid_idu_i     : bundle valid
//   dyn_ready_idu_o     : unit idle and accepting
//   rd_exeu_o           : writeback register index
//   wrtbck_dat_exeu_o   : writeback data
//   wrtbck_en_exeu_o    : writeback strobe (one cycle)
//   illegal_instr_o     : one-cycle pulse for an invalid bundle
//   halt_o              : sticky halt after ebreak
module exu
  import exu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DYN_INST_WIDTH-1:0] dyn_instr_idu_i,
  input  logic                      dyn_valid_idu_i,
  output logic                      dyn_ready_idu_o,
  output logic [RD_LEN_STA-1:0]     rd_exeu_o,
  output logic [DATA_WIDTH-1:0]     wrtbck_dat_exeu_o,
  output logic                      wrtbck_en_exeu_o,
  output logic                      illegal_instr_o,
  output logic                      halt_o
);

  exu_st_e               state;
  dyn_instr_t            in_c;
  dyn_instr_t            inst;
  logic                  accept_c;
  logic [DATA_WIDTH-1:0] in_b_c;
  logic [DATA_WIDTH-1:0] op_a_c;
  logic [DATA_WIDTH-1:0] op_b_c;
  logic [DATA_WIDTH-1:0] alu_c;
  logic [DATA_WIDTH-1:0] shift_res_c;
  logic                  shift_done_c;
  logic                  is_shift_c;
  logic                  does_wb_c;
  logic                  is_ebreak_c;
  logic                  unused_bits;

  assign in_c     = dyn_instr_t'(dyn_instr_idu_i);
  assign accept_c = dyn_valid_idu_i && dyn_ready_idu_o;
  assign in_b_c   = in_c.use_imm ? in_c.imm : in_c.rs2_val;

  assign op_a_c = inst.rs1_val;
  assign op_b_c = inst.use_imm ? inst.imm : inst.rs2_val;

  // func3 = x01 selects the iterative shifter; invalid bundles do no ALU work
  assign is_shift_c  = (inst.alu_op[1:0] == 2'b01) && !inst.invld_instr;
  assign is_ebreak_c = (inst.instr_type == IT_EBREAK) && !inst.invld_instr;
  assign does_wb_c   = inst.use_rd && !inst.invld_instr && (inst.rd != '0) &&
                       ((inst.instr_type == IT_R) || (inst.instr_type == IT_I) ||
                        (inst.instr_type == IT_ISHIFT));

  // Fields carried by the bundle that execute does not consume
  assign unused_bits = ^{inst.rs1, inst.rs2, inst.pc, inst.fu_id,
                         inst.use_rs1, inst.use_rs2, in_b_c[DATA_WIDTH-1:SHAMT_WIDTH]};

  // Single-cycle ALU; shift codes are served by the shifter
  always_comb begin
    alu_c = '0;
    unique case (inst.alu_op[2:0])
      3'b000:  alu_c = inst.alu_op[3] ? (op_a_c - op_b_c) : (op_a_c + op_b_c);
      3'b010:  alu_c = DATA_WIDTH'($signed(op_a_c) < $signed(op_b_c));
      3'b011:  alu_c = DATA_WIDTH'(op_a_c < op_b_c);
      3'b100:  alu_c = op_a_c ^ op_b_c;
      3'b110:  alu_c = op_a_c | op_b_c;
      3'b111:  alu_c = op_a_c & op_b_c;
      default: alu_c = '0;
    endcase
  end

  // Shifter is loaded straight from the incoming bundle so EXEC starts shifting at once
  exu_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_c),
    .step     (state == EXU_EXEC),
    .left     (in_c.alu_op[2:0] == 3'b001),
    .arith    (in_c.alu_op[3]),
    .a        (in_c.rs1_val),
    .shamt    (in_b_c[SHAMT_WIDTH-1:0]),
    .result_c (shift_res_c),
    .done_c   (shift_done_c)
  );

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= EXU_IDLE;
      inst              <= '0;
      dyn_ready_idu_o   <= 1'b0;
      rd_exeu_o         <= '0;
      wrtbck_dat_exeu_o <= '0;
      wrtbck_en_exeu_o  <= 1'b0;
      illegal_instr_o   <= 1'b0;
      halt_o            <= 1'b0;
    end else begin
      wrtbck_en_exeu_o <= 1'b0;
      illegal_instr_o  <= 1'b0;
      unique case (state)
        EXU_IDLE: begin
          dyn_ready_idu_o <= 1'b1;
          if (accept_c) begin
            inst            <= in_c;
            dyn_ready_idu_o <= 1'b0;
            state           <= EXU_EXEC;
          end
        end
        EXU_EXEC: begin
          if (!is_shift_c || shift_done_c) begin
            rd_exeu_o         <= inst.rd;
            wrtbck_dat_exeu_o <= inst.invld_instr ? '0 : (is_shift_c ? shift_res_c : alu_c);
            wrtbck_en_exeu_o  <= does_wb_c;
            illegal_instr_o   <= inst.invld_instr;
            state             <= EXU_WB;
          end
        end
        EXU_WB: begin
          if (is_ebreak_c) begin
            halt_o <= 1'b1;
            state  <= EXU_HALT;
          end else begin
            dyn_ready_idu_o <= 1'b1;
            state           <= EXU_IDLE;
          end
        end
        EXU_HALT: begin
          dyn_ready_idu_o <= 1'b0;
        end
        default: state <= EXU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exu.sv
// tb_exu: scoreboard bench for exu. The driver pushes expected writeback /
// illegal events (with the cycle they must appear in) computed from a plain
// arithmetic reference model; an independent monitor pops and compares.
module tb_exu;
  import exu_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [DYN_INST_WIDTH-1:0] bus = '0;
  logic                      valid = 1'b0;
  logic                      ready;
  logic [RD_LEN_STA-1:0]     rd;
  logic [DATA_WIDTH-1:0]     data;
  logic                      wb_en;
  logic                      ill;
  logic                      halt;

  exu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dyn_instr_idu_i   (bus),
    .dyn_valid_idu_i   (valid),
    .dyn_ready_idu_o   (ready),
    .rd_exeu_o         (rd),
    .wrtbck_dat_exeu_o (data),
    .wrtbck_en_exeu_o  (wb_en),
    .illegal_instr_o   (ill),
    .halt_o            (halt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_ill;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU: plain arithmetic on whole words
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op[2:0])
      3'b000:  return op[3] ? a - b : a + b;
      3'b001:  return a << sh;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return op[3] ? 32'($signed(a) >>> sh) : (a >> sh);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] opb(input dyn_instr_t d);
    return d.use_imm ? d.imm : d.rs2_val;
  endfunction

  // Cycles from acceptance to the strobe cycle
  function automatic int latency(input dyn_instr_t d);
    int k;
    k = int'(opb(d) & 32'h1f);
    if (!d.invld_instr && d.alu_op[1:0] == 2'b01) return 1 + ((k < 1) ? 1 : k);
    return 2;
  endfunction

  function automatic bit writes(input dyn_instr_t d);
    return d.use_rd && !d.invld_instr && (d.rd != 5'd0) &&
           (d.instr_type == IT_R || d.instr_type == IT_I || d.instr_type == IT_ISHIFT);
  endfunction

  function automatic dyn_instr_t mk(input instr_type_e ty, input logic [3:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic ui, input logic [4:0] rdi,
                                    input logic urd, input logic inv);
    dyn_instr_t d;
    d.rs1        = 5'($urandom);
    d.rs2        = 5'($urandom);
    d.rd         = rdi;
    d.rs1_val    = a;
    d.rs2_val    = ui ? $urandom : b;
    d.imm        = ui ? b : $urandom;
    d.pc         = $urandom;
    d.fu_id      = 2'($urandom);
    d.instr_type = ty;
    d.use_rs1    = 1'b1;
    d.use_rs2    = !ui;
    d.use_imm    = ui;
    d.use_rd     = urd;
    d.invld_instr = inv;
    d.alu_op     = op;
    return d;
  endfunction

  // Present a bundle, wait for acceptance, record expected event if asked
  task automatic issue(input dyn_instr_t d, input bit push, output int t);
    int waited;
    ev_t e;
    waited = 0;
    @(negedge clk);
    valid = 1'b1;
    bus   = d;
    while (!ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1", waited);
      valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    if (push) begin
      if (d.invld_instr) begin
        e.is_ill = 1'b1; e.rd = 5'd0; e.data = 32'd0; e.cyc = t + 2;
        sb.push_back(e);
      end else if (writes(d)) begin
        e.is_ill = 1'b0; e.rd = d.rd; e.data = ref_alu(d.rs1_val, opb(d), d.alu_op);
        e.cyc = t + latency(d);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    bus   = DYN_INST_WIDTH'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  // Monitor: every strobe or illegal pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && (wb_en || ill)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got en=%0b ill=%0b rd=%0d data=0x%08h expected no event (cycle %0d)",
                 wb_en, ill, rd, data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("strobe_en", 32'(wb_en), 32'(!mon_e.is_ill));
        chk("illegal_pulse", 32'(ill), 32'(mon_e.is_ill));
        if (!mon_e.is_ill) begin
          chk("wb_rd", 32'(rd), 32'(mon_e.rd));
          chk("wb_data", data, mon_e.data);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag, input logic exp_ready);
    chk({tag, "_ready"}, 32'(ready), 32'(exp_ready));
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_en"}, 32'(wb_en), 32'd0);
    chk({tag, "_ill"}, 32'(ill), 32'd0);
    chk({tag, "_halt"}, 32'(halt), 32'd0);
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_scoreboard_left"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  instr_type_e tys[5] = '{IT_R, IT_I, IT_ISHIFT, IT_ECALL, IT_LOAD};

  initial begin
    int t;
    dyn_instr_t d;
    logic [3:0] op;
    instr_type_e ty;
    logic ui;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(ready), 32'd1);

    // addi x1,x0,5 with ready timing
    issue(mk(IT_I, ALUOP_ADD, 32'd0, 32'd5, 1'b1, 5'd1, 1'b1, 1'b0), 1'b1, t);
    @(negedge clk); chk("addi_ready_t1", 32'(ready), 32'd0);
    @(negedge clk); chk("addi_ready_t2", 32'(ready), 32'd0);
    @(negedge clk); chk("addi_ready_t3", 32'(ready), 32'd1);

    // sub / slt / sltu
    issue(mk(IT_R, ALUOP_SUB, 32'd0, 32'd1, 1'b0, 5'd3, 1'b1, 1'b0), 1'b1, t);
    issue(mk(IT_R, ALUOP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd4, 1'b1, 1'b0), 1'b1, t);
    issue(mk(IT_R, ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd5, 1'b1, 1'b0), 1'b1, t);

    // srai by 31 and slli by 0
    issue(mk(IT_ISHIFT, ALUOP_SRA, 32'h8000_0000, 32'd31, 1'b1, 5'd6, 1'b1, 1'b0), 1'b1, t);
    issue(mk(IT_ISHIFT, ALUOP_SLL, 32'h0000_1234, 32'd0, 1'b1, 5'd7, 1'b1, 1'b0), 1'b1, t);

    // rd=0 suppresses write; invalid bundle pulses illegal
    issue(mk(IT_I, ALUOP_ADD, 32'd7, 32'd1, 1'b1, 5'd0, 1'b1, 1'b0), 1'b1, t);
    issue(mk(IT_R, ALUOP_ADD, 32'd7, 32'd1, 1'b0, 5'd9, 1'b1, 1'b1), 1'b1, t);
    drain("directed");

    // Reset in the middle of a 20-bit srl: no writeback may ever appear
    issue(mk(IT_R, ALUOP_SRL, 32'hF000_0000, 32'd20, 1'b0, 5'd8, 1'b1, 1'b0), 1'b0, t);
    while (cyc < t + 10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midshift_reset", 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(mk(IT_I, ALUOP_ADD, 32'd100, 32'hFFFF_FFFF, 1'b1, 5'd9, 1'b1, 1'b0), 1'b1, t);
    drain("post_reset");

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      ty = tys[$urandom_range(0, 4)];
      op = 4'($urandom_range(0, 15));
      ui = (ty == IT_R) ? 1'b0 : 1'b1;
      if (ty == IT_ISHIFT) op[1:0] = 2'b01;
      d = mk(ty, op, $urandom, $urandom, ui, 5'($urandom),
             ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
      issue(d, 1'b1, t);
    end
    drain("random");

    // ebreak: no write, halt from T+3, ready held low with valid asserted
    issue(mk(IT_EBREAK, ALUOP_ADD, 32'd1, 32'd1, 1'b1, 5'd10, 1'b1, 1'b0), 1'b0, t);
    valid = 1'b1;
    bus   = mk(IT_I, ALUOP_ADD, 32'd1, 32'd2, 1'b1, 5'd11, 1'b1, 1'b0);
    while (cyc < t + 12) begin
      @(negedge clk);
      if (cyc == t + 2) chk("halt_before", 32'(halt), 32'd0);
      if (cyc >= t + 3) begin
        chk("halt_sticky", 32'(halt), 32'd1);
        chk("ready_in_halt", 32'(ready), 32'd0);
      end
    end
    valid = 1'b0;
    chk("final_scoreboard_left", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
